// File: rtl/axi4l_pkg.sv
// Shared definitions for the AXI4-Lite command master.
//   - AXI4-Lite xRESP encodings
//   - rsp_err codes reported on the command response port
//   - FSM state type (StAbort exists only when AXI4L_CMD_MASTER_TIMEOUT_EN is defined)
//   - resp_to_err(): maps a B/R response onto an rsp_err code
package axi4l_pkg;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespExokay = 2'b01;
   localparam logic [1:0] RespSlverr = 2'b10;
   localparam logic [1:0] RespDecerr = 2'b11;

   localparam logic [1:0] ErrOkay    = 2'b00;
   localparam logic [1:0] ErrTimeout = 2'b01;
   localparam logic [1:0] ErrSlverr  = 2'b10;
   localparam logic [1:0] ErrDecerr  = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StWrResp,
      StRdReq,
      StRdResp,
      StResp
`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
      , StAbort
`endif
   } state_e;

   // EXOKAY is not legal on AXI4-Lite; fold it into OKAY so it can never be
   // mistaken for the timeout code, which shares its encoding.
   function automatic logic [1:0] resp_to_err(input logic [1:0] resp);
      logic [1:0] err;
      err = ErrOkay;
      case (resp)
         RespSlverr: err = ErrSlverr;
         RespDecerr: err = ErrDecerr;
         default:    err = ErrOkay;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/axi4l_watchdog.sv
// Cycle watchdog for the AXI4-Lite command master.
//   aclk, areset_n : clock, asynchronous active-low reset
//   clear          : restart the count (command accepted)
//   enable         : count this cycle (transaction in flight)
//   expired        : this is the TIMEOUT-th counted cycle since clear
// Instantiated only when AXI4L_CMD_MASTER_TIMEOUT_EN is defined.
module axi4l_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic aclk,
   input  logic areset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (32'(cnt_q) < TIMEOUT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // cnt_q counts cycles already spent, so the current cycle is number cnt_q + 1.
   assign expired = enable && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/axi4l_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response port.
//   aclk, areset_n            : clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_we, cmd_addr, cmd_wdata : command in (one at a time)
//   rsp_valid/ready, rsp_rdata, rsp_err          : response out, held until rsp_ready
//   aw*, w*, b*, ar*, r*      : AXI4-Lite master channels
// All outputs come straight from flops (or are constants).
// Optional watchdog: define AXI4L_CMD_MASTER_TIMEOUT_EN to enable TIMEOUT-cycle abort.
module axi4l_cmd_master #(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  aclk,
   input  logic                  areset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic [1:0]            rsp_err,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [2:0]            awprot,
   output logic                  wvalid,
   input  logic                  wready,
   output logic [31:0]           wdata,
   output logic [3:0]            wstrb,
   input  logic                  bvalid,
   output logic                  bready,
   input  logic [1:0]            bresp,
   output logic                  arvalid,
   input  logic                  arready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [2:0]            arprot,
   input  logic                  rvalid,
   output logic                  rready,
   input  logic [31:0]           rdata,
   input  logic [1:0]            rresp
);

   import axi4l_pkg::*;

   state_e                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  bready_q, bready_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic [1:0]            rsp_err_q, rsp_err_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  accept;

   assign accept = cmd_valid & cmd_ready_q;

`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
   logic is_write_q, is_write_d;
   // Set on abort: a B or R beat is still owed by the slave and must be drained.
   logic owed_q, owed_d;
   logic wd_enable, wd_expired;

   assign wd_enable = (state_q == StWrReq) || (state_q == StWrResp) ||
                      (state_q == StRdReq) || (state_q == StRdResp);

   axi4l_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .aclk     (aclk),
      .areset_n (areset_n),
      .clear    (accept),
      .enable   (wd_enable),
      .expired  (wd_expired)
   );
`endif

   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
      is_write_d  = is_write_q;
      owed_d      = owed_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               addr_d = cmd_addr;
`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
               is_write_d = cmd_we;
`endif
               if (cmd_we) begin
                  wdata_d   = cmd_wdata;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = StWrReq;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = StRdReq;
               end
            end
         end
         StWrReq: begin
            // AW and W complete independently; move on once both are gone.
            if (awvalid_q && awready) awvalid_d = 1'b0;
            if (wvalid_q && wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = StWrResp;
            end
         end
         StWrResp: begin
            if (bvalid && bready_q) begin
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = resp_to_err(bresp);
               state_d     = StResp;
            end
         end
         StRdReq: begin
            if (arvalid_q && arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = StRdResp;
            end
         end
         StRdResp: begin
            if (rvalid && rready_q) begin
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = rdata;
               rsp_err_d   = resp_to_err(rresp);
               state_d     = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
         StAbort: begin
            // Let pending requests finish, swallow the late beat, and hold the
            // timeout response; leave only when all of that is done.
            if (awvalid_q && awready) awvalid_d = 1'b0;
            if (wvalid_q && wready)   wvalid_d  = 1'b0;
            if (arvalid_q && arready) arvalid_d = 1'b0;
            if ((bvalid && bready_q) || (rvalid && rready_q)) owed_d = 1'b0;
            bready_d = is_write_q & owed_d;
            rready_d = ~is_write_q & owed_d;
            if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
            if (!rsp_valid_d && !owed_d && !awvalid_d && !wvalid_d && !arvalid_d) begin
               state_d = StIdle;
            end
         end
`endif
         default: begin
            state_d = StIdle;
         end
      endcase

`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
      // A real response completing in the expiry cycle wins over the timeout.
      if (wd_expired && (state_d != StResp)) begin
         state_d     = StAbort;
         rsp_valid_d = 1'b1;
         rsp_rdata_d = '0;
         rsp_err_d   = ErrTimeout;
         owed_d      = 1'b1;
         bready_d    = is_write_q;
         rready_d    = ~is_write_q;
      end
`endif

      cmd_ready_d = (state_d == StIdle);
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= ErrOkay;
         addr_q      <= '0;
         wdata_q     <= '0;
`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
         is_write_q  <= 1'b0;
         owed_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
         is_write_q  <= is_write_d;
         owed_q      <= owed_d;
`endif
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign awvalid   = awvalid_q;
   assign awaddr    = addr_q;
   assign awprot    = 3'b000;
   assign wvalid    = wvalid_q;
   assign wdata     = wdata_q;
   assign wstrb     = 4'hF;
   assign bready    = bready_q;
   assign arvalid   = arvalid_q;
   assign araddr    = addr_q;
   assign arprot    = 3'b000;
   assign rready    = rready_q;

endmodule

// File: doc/axi4l_cmd_master.md
AXI4L_CMD_MASTER -- requirements
Module: axi4l_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3: byte-address width of the AXI4-Lite bus.
REQ-002 SHALL have parameter TIMEOUT, default 255: watchdog limit in aclk cycles (used only with the timeout macro).
REQ-003 SHALL have one clock, aclk; reset areset_n is asynchronous and active-low.
REQ-004 SHALL have ports (name, direction, width, meaning):
- aclk, in, 1: clock.
- areset_n, in, 1: async active-low reset.
- cmd_valid / cmd_ready, in / out, 1: command handshake.
- cmd_we, in, 1: 1 = write, 0 = read.
- cmd_addr, in, ADDR_WIDTH: byte address.
- cmd_wdata, in, 32: write data.
- rsp_valid / rsp_ready, out / in, 1: response handshake.
- rsp_rdata, out, 32: read data; 0 for writes.
- rsp_err, out, 2: 00 OKAY, 01 timeout, 10 SLVERR, 11 DECERR.
- awvalid/awready, awaddr[ADDR_WIDTH-1:0], awprot[2:0]: AXI4-Lite AW channel, master side.
- wvalid/wready, wdata[31:0], wstrb[3:0]: W channel.
- bvalid/bready, bresp[1:0]: B channel.
- arvalid/arready, araddr[ADDR_WIDTH-1:0], arprot[2:0]: AR channel.
- rvalid/rready, rdata[31:0], rresp[1:0]: R channel.

Function
REQ-005 SHALL process one transaction at a time. cmd_ready = 1 only in IDLE. A command is accepted when cmd_valid & cmd_ready.
REQ-006 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP, ABORT.
REQ-007 Write accepted in cycle N: SHALL register the address and data, and assert awvalid and wvalid together from cycle N+1 (state WR_REQ).
REQ-008 In WR_REQ, each of awvalid and wvalid SHALL drop independently in the cycle after its own handshake. The FSM goes to WR_RESP once both handshakes are done, in either order or in the same cycle.
REQ-009 bready SHALL be 1 only in WR_RESP. On bvalid: capture bresp into rsp_err, set rsp_rdata = 0, go to RESP.
REQ-010 Read accepted in cycle N: SHALL assert arvalid from N+1 (RD_REQ). After the arready handshake go to RD_RESP with rready = 1. On rvalid: capture rdata and rresp, go to RESP.
REQ-011 SHALL assert rsp_valid in RESP and hold rsp_valid and rsp_rdata/rsp_err stable until rsp_ready; then return to IDLE. Back-to-back commands are therefore separated by at least one IDLE cycle.
REQ-012 Once asserted, a VALID SHALL NOT deassert before its handshake. awaddr/araddr/wdata SHALL stay stable while their VALID is high.
REQ-013 awprot = arprot = 3'b000 and wstrb = 4'hF, constant.
REQ-014 SHALL use only registered outputs; no combinational path from any input to any output.

Reset
REQ-015 While areset_n = 0, SHALL force: state IDLE, cmd_ready 0, all VALIDs 0, bready 0, rready 0, rsp_valid 0, rsp_rdata 0, rsp_err 00, watchdog 0.
REQ-016 In the first cycle after reset release, cmd_ready SHALL be 1. Reset mid-transaction abandons the transaction and produces no response.

Configuration
REQ-017 Macro AXI4L_CMD_MASTER_TIMEOUT_EN controls the watchdog.
- Defined: the watchdog clears on command accept and counts each cycle outside IDLE/RESP. On reaching TIMEOUT it SHALL:
  - present a response with rsp_err = 01 and rsp_rdata = 0;
  - enter ABORT, which keeps pending VALIDs asserted until their handshakes, holds bready/rready = 1, and discards the late B/R beat;
  - hold the timeout response until rsp_ready; both conditions must be met before returning to IDLE.
- Undefined: no counter logic, no ABORT state, and the block may wait forever.

Structure
REQ-018 Package axi4l_pkg SHALL hold the resp encodings (OKAY/EXOKAY/SLVERR/DECERR), the rsp_err codes and the FSM state typedef.
REQ-019 The watchdog SHALL be a sub-module axi4l_watchdog (inputs clear, enable; output expired), instantiated only under the macro.

Verification
REQ-020 Write 0x1234_5678 to addr 0x0; slave holds awready 3 cycles, wready 1 cycle -> AW and W complete independently, one B beat, rsp_err 00, rsp_rdata 0.
REQ-021 Read addr 0x4; slave returns rdata 0xDEAD_BEEF, rresp 00, after 2 cycles -> rsp_rdata 0xDEADBEEF, rsp_err 00. No read accepted while the write is pending.
REQ-022 Write with slave bresp 10 -> rsp_err 10. Read with rresp 11 -> rsp_err 11.
REQ-023 rsp_ready held low 5 cycles -> rsp_valid and data stable throughout, and cmd_ready stays 0.
REQ-024 With the macro and TIMEOUT = 8, the slave never asserts bvalid -> rsp_err 01 after 8 cycles. A later bvalid is consumed and not reported, then cmd_ready returns to 1.
REQ-025 areset_n pulsed low during RD_RESP -> all outputs take reset values asynchronously. The next read completes normally.
